// File: rtl/udp_pkg.sv
// -----------------------------------------------------------------------------
// udp_pkg
// Shared constants and types for the UDP header scheduler.
//   UDP_HDR_BYTES    : fixed UDP header size added to every payload length
//   MAX_UDP_PAYLOAD  : largest payload that fits a 1500-byte IPv4 MTU
//   sched_state_e    : scheduler state encoding
// -----------------------------------------------------------------------------
package udp_pkg;

   localparam int unsigned UDP_HDR_BYTES   = 8;
   localparam int unsigned MAX_UDP_PAYLOAD = 1472;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_OUT = 2'd2
   } sched_state_e;

endpackage : udp_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational rotating-priority arbiter. Searches req upward starting at
// ptr, wrapping modulo NUM_REQ, and grants the first set bit.
// Ports:
//   req       in  NUM_REQ  request vector
//   ptr       in  ID_W     index with highest priority this cycle
//   gnt       out NUM_REQ  one-hot grant (all zero when nothing requested)
//   gnt_id    out ID_W     index of the granted requester
//   gnt_valid out 1        at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    gnt_id,
   output logic               gnt_valid
);

   always_comb begin
      int idx;
      // NOTE: every output gets a default before the loop so no path leaves
      // a value unassigned, which would otherwise infer a latch.
      gnt       = '0;
      gnt_id    = '0;
      gnt_valid = 1'b0;
      idx       = 0;
      for (int off = 0; off < NUM_REQ; off++) begin
         idx = (int'(ptr) + off) % NUM_REQ;
         if (!gnt_valid && req[idx]) begin
            gnt[idx]  = 1'b1;
            gnt_id    = ID_W'(idx);
            gnt_valid = 1'b1;
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/udp_hdr_scheduler.sv
// -----------------------------------------------------------------------------
// udp_hdr_scheduler
// Shares one single-entry UDP header builder among NUM_REQ requesters.
// A request is granted round-robin, oversize payloads are rejected with an
// error pulse, legal ones are handed to the builder with UDP length = len + 8,
// and done_valid reports the requester once the built header leaves the
// builder. Only one header is in flight at a time.
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   req_valid/req_ready  per-requester handshake (req_ready is a 1-cycle pulse)
//   req_src_port         packed source ports, requester i at [16i+15:16i]
//   req_dst_port         packed destination ports
//   req_payload_len      packed payload lengths in bytes
//   hdr_valid_in/_ready_in  builder input handshake
//   hdr_src_port/_dst_port/_udp_length  fields presented to the builder
//   hdr_out_valid/_ready builder output handshake (monitored only)
//   done_valid/done_id   header accepted downstream, owning requester
//   err_valid/err_id     request rejected as oversize, owning requester
// -----------------------------------------------------------------------------
module udp_hdr_scheduler
   import udp_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int ID_W        = 2,
   parameter int MAX_PAYLOAD = MAX_UDP_PAYLOAD
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*16-1:0]   req_src_port,
   input  logic [NUM_REQ*16-1:0]   req_dst_port,
   input  logic [NUM_REQ*16-1:0]   req_payload_len,
   output logic                    hdr_valid_in,
   input  logic                    hdr_ready_in,
   output logic [15:0]             hdr_src_port,
   output logic [15:0]             hdr_dst_port,
   output logic [15:0]             hdr_udp_length,
   input  logic                    hdr_out_valid,
   input  logic                    hdr_out_ready,
   output logic                    done_valid,
   output logic [ID_W-1:0]         done_id,
   output logic                    err_valid,
   output logic [ID_W-1:0]         err_id
);

   localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);
   localparam logic [15:0] HDR_LEN = 16'(UDP_HDR_BYTES);

   sched_state_e        state;
   logic [ID_W-1:0]     rr_ptr;
   logic [ID_W-1:0]     grant_id;

   logic [NUM_REQ-1:0]  arb_gnt;
   logic [ID_W-1:0]     arb_id;
   logic                arb_valid;
   logic [15:0]         cand_src;
   logic [15:0]         cand_dst;
   logic [15:0]         cand_len;
   logic                grant_en;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_arbiter (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .gnt       (arb_gnt),
      .gnt_id    (arb_id),
      .gnt_valid (arb_valid)
   );

   assign cand_src = req_src_port[int'(arb_id)*16 +: 16];
   assign cand_dst = req_dst_port[int'(arb_id)*16 +: 16];
   assign cand_len = req_payload_len[int'(arb_id)*16 +: 16];

   // While req_ready or done_valid is high the just-served requester may still
   // show req_valid (or the pointer has only just moved), so arbitration waits
   // one cycle to avoid serving the same request twice.
   assign grant_en = (state == IDLE) && arb_valid && (req_ready == '0) && !done_valid;

   function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
      return (int'(id) == NUM_REQ - 1) ? '0 : ID_W'(int'(id) + 1);
   endfunction

   // NOTE: all state updates use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state          <= IDLE;
         rr_ptr         <= '0;
         grant_id       <= '0;
         req_ready      <= '0;
         hdr_valid_in   <= 1'b0;
         hdr_src_port   <= '0;
         hdr_dst_port   <= '0;
         hdr_udp_length <= '0;
         done_valid     <= 1'b0;
         done_id        <= '0;
         err_valid      <= 1'b0;
         err_id         <= '0;
      end else begin
         // Pulses default low; the branches below raise them for one cycle.
         req_ready  <= '0;
         done_valid <= 1'b0;
         err_valid  <= 1'b0;

         case (state)
            IDLE: begin
               if (grant_en) begin
                  grant_id <= arb_id;
                  if (cand_len > MAX_LEN) begin
                     // Oversize: consume and report without touching the builder.
                     req_ready <= arb_gnt;
                     err_valid <= 1'b1;
                     err_id    <= arb_id;
                     rr_ptr    <= next_ptr(arb_id);
                  end else begin
                     hdr_src_port   <= cand_src;
                     hdr_dst_port   <= cand_dst;
                     hdr_udp_length <= cand_len + HDR_LEN;
                     hdr_valid_in   <= 1'b1;
                     state          <= ISSUE;
                  end
               end
            end

            ISSUE: begin
               if (hdr_ready_in) begin
                  hdr_valid_in        <= 1'b0;
                  req_ready[grant_id] <= 1'b1;
                  state               <= WAIT_OUT;
               end
            end

            WAIT_OUT: begin
               if (hdr_out_valid && hdr_out_ready) begin
                  done_valid <= 1'b1;
                  done_id    <= grant_id;
                  rr_ptr     <= next_ptr(grant_id);
                  state      <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule : udp_hdr_scheduler

// File: tb/tb_udp_hdr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_udp_hdr_scheduler
// Directed bench for udp_hdr_scheduler with a single-entry builder model and
// counting requester models. Expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_udp_hdr_scheduler;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   logic                   clk;
   logic                   rstn;
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ*16-1:0]  req_src_port;
   logic [NUM_REQ*16-1:0]  req_dst_port;
   logic [NUM_REQ*16-1:0]  req_payload_len;
   logic                   hdr_valid_in;
   logic                   hdr_ready_in;
   logic [15:0]            hdr_src_port;
   logic [15:0]            hdr_dst_port;
   logic [15:0]            hdr_udp_length;
   logic                   hdr_out_valid;
   logic                   hdr_out_ready;
   logic                   done_valid;
   logic [ID_W-1:0]        done_id;
   logic                   err_valid;
   logic [ID_W-1:0]        err_id;

   udp_hdr_scheduler #(
      .NUM_REQ     (NUM_REQ),
      .ID_W        (ID_W),
      .MAX_PAYLOAD (1472)
   ) dut (
      .clk             (clk),
      .rstn            (rstn),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_src_port    (req_src_port),
      .req_dst_port    (req_dst_port),
      .req_payload_len (req_payload_len),
      .hdr_valid_in    (hdr_valid_in),
      .hdr_ready_in    (hdr_ready_in),
      .hdr_src_port    (hdr_src_port),
      .hdr_dst_port    (hdr_dst_port),
      .hdr_udp_length  (hdr_udp_length),
      .hdr_out_valid   (hdr_out_valid),
      .hdr_out_ready   (hdr_out_ready),
      .done_valid      (done_valid),
      .done_id         (done_id),
      .err_valid       (err_valid),
      .err_id          (err_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- requester models ----------------
   int issue_cnt  [NUM_REQ];   // requests posted (written by stimulus only)
   int served_cnt [NUM_REQ];   // req_ready pulses seen (written by monitor only)

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) req_valid[i] = issue_cnt[i] > served_cnt[i];
   end

   // ---------------- single-entry builder model ----------------
   logic        stall;
   logic        out_rdy;
   logic        bld_full;
   logic [63:0] bld_hdr;

   assign hdr_ready_in  = !bld_full && !stall;
   assign hdr_out_valid = bld_full;
   assign hdr_out_ready = out_rdy;

   always @(posedge clk) begin
      if (!rstn) begin
         bld_full <= 1'b0;
      end else begin
         if (bld_full && hdr_out_ready) bld_full <= 1'b0;
         if (hdr_valid_in && hdr_ready_in) begin
            bld_full <= 1'b1;
            bld_hdr  <= {hdr_src_port, hdr_dst_port, hdr_udp_length, 16'h0000};
         end
      end
   end

   // ---------------- monitor ----------------
   int   done_q [$];
   int   err_q  [$];
   int   len_q  [$];
   int   hdr_issues;
   int   multi_rr;
   int   both_pulse;
   logic hv_prev;

   initial begin
      hdr_issues = 0; multi_rr = 0; both_pulse = 0; hv_prev = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) served_cnt[i] = 0;
   end

   always @(negedge clk) begin
      if (done_valid) done_q.push_back(int'(done_id));
      if (err_valid)  err_q.push_back(int'(err_id));
      if (hdr_valid_in && !hv_prev) begin
         hdr_issues <= hdr_issues + 1;
         len_q.push_back(int'(hdr_udp_length));
      end
      hv_prev <= hdr_valid_in;
      for (int i = 0; i < NUM_REQ; i++)
         if (req_ready[i]) served_cnt[i] <= served_cnt[i] + 1;
      if ($countones(req_ready) > 1) multi_rr <= multi_rr + 1;
      if (done_valid && err_valid)   both_pulse <= both_pulse + 1;
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int q_at(input int q[$], input int idx);
      return (idx < q.size()) ? q[idx] : -1;
   endfunction

   function automatic logic [63:0] all_outputs();
      return 64'({req_ready, hdr_valid_in, hdr_src_port, hdr_dst_port, hdr_udp_length,
                  done_valid, done_id, err_valid, err_id});
   endfunction

   task automatic set_req(input int i, input logic [15:0] src, input logic [15:0] dst,
                          input logic [15:0] len);
      req_src_port[i*16 +: 16]    = src;
      req_dst_port[i*16 +: 16]    = dst;
      req_payload_len[i*16 +: 16] = len;
      issue_cnt[i]                = issue_cnt[i] + 1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn    = 1'b0;
      stall   = 1'b0;
      out_rdy = 1'b1;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic wait_done(input string tag, input int target);
      int n = 0;
      while (done_q.size() < target && n < 300) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(done_q.size()), 64'(target));
   endtask

   task automatic wait_out_valid(input string tag);
      int n = 0;
      while (!hdr_out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(hdr_out_valid), 64'd1);
   endtask

   // ---------------- stimulus ----------------
   int base, ebase, ibase, lbase, s1;
   int dbase, s0, s3;
   logic stable;
   int   lens [NUM_REQ] = '{0, 1471, 40, 700};

   initial begin
      rstn = 1'b0; stall = 1'b0; out_rdy = 1'b1;
      req_src_port = '0; req_dst_port = '0; req_payload_len = '0;
      for (int i = 0; i < NUM_REQ; i++) issue_cnt[i] = 0;
      repeat (3) @(negedge clk);
      check("reset_outputs", all_outputs(), 64'd0);
      rstn = 1'b1;
      @(negedge clk);

      // ---- single request on requester 2, cycle by cycle ----
      set_req(2, 16'h1234, 16'h4791, 16'd100);
      @(negedge clk);
      check("single_valid", 64'(hdr_valid_in), 64'd1);
      check("single_fields", {16'h0, hdr_src_port, hdr_dst_port, hdr_udp_length},
            64'h0000_1234_4791_006C);
      check("single_no_ready_yet", 64'(req_ready), 64'h0);
      @(negedge clk);
      check("single_req_ready", 64'({req_ready, hdr_valid_in}), 64'b0100_0);
      @(negedge clk);
      check("single_done", 64'({done_valid, done_id}), 64'b1_10);
      check("single_builder_hdr", bld_hdr, 64'h1234_4791_006C_0000);
      repeat (4) @(negedge clk);
      check("single_one_pulse", 64'(served_cnt[2]), 64'd1);

      // ---- all four continuously valid, two each ----
      do_reset();
      base  = done_q.size();
      lbase = len_q.size();
      for (int i = 0; i < NUM_REQ; i++) begin
         set_req(i, 16'(16'h1000 + i), 16'(16'h2000 + i), 16'(lens[i]));
         issue_cnt[i] = issue_cnt[i] + 1;
      end
      wait_done("rr_eight_done", base + 8);
      for (int k = 0; k < 8; k++) begin
         check($sformatf("rr_order_%0d", k), 64'(q_at(done_q, base + k)), 64'(k % 4));
         check($sformatf("rr_len_%0d", k), 64'(q_at(len_q, lbase + k)),
               64'(lens[k % 4] + 8));
      end
      for (int i = 0; i < NUM_REQ; i++)
         check($sformatf("rr_served_%0d", i), 64'(served_cnt[i]), 64'(i == 2 ? 3 : 2));

      // ---- oversize on 1, boundary 1472 on 3 ----
      do_reset();
      base  = done_q.size();
      ebase = err_q.size();
      ibase = hdr_issues;
      lbase = len_q.size();
      s1    = served_cnt[1];
      set_req(1, 16'h0111, 16'h0222, 16'd1473);
      set_req(3, 16'h0333, 16'h0444, 16'd1472);
      wait_done("ovs_done", base + 1);
      repeat (3) @(negedge clk);
      check("ovs_err_count", 64'(err_q.size()), 64'(ebase + 1));
      check("ovs_err_id", 64'(q_at(err_q, ebase)), 64'd1);
      check("ovs_issue_count", 64'(hdr_issues), 64'(ibase + 1));
      check("ovs_len_1480", 64'(q_at(len_q, lbase)), 64'd1480);
      check("ovs_done_id", 64'(q_at(done_q, base)), 64'd3);
      check("ovs_consumed", 64'(served_cnt[1]), 64'(s1 + 1));

      // ---- downstream backpressure for 10 cycles ----
      do_reset();
      out_rdy = 1'b0;
      base    = done_q.size();
      set_req(0, 16'h0aaa, 16'h0bbb, 16'd10);
      wait_out_valid("bp_out_valid");
      set_req(1, 16'h0ccc, 16'h0ddd, 16'd11);
      ibase = hdr_issues;
      repeat (10) @(negedge clk);
      check("bp_no_new_issue", 64'({hdr_issues, hdr_valid_in}), 64'({ibase, 1'b0}));
      check("bp_no_done", 64'(done_q.size()), 64'(base));
      out_rdy = 1'b1;
      @(negedge clk);
      check("bp_done_next", 64'({done_valid, done_id}), 64'b1_00);
      wait_done("bp_second_done", base + 2);
      check("bp_second_id", 64'(q_at(done_q, base + 1)), 64'd1);

      // ---- builder input stall for 5 cycles ----
      do_reset();
      stall  = 1'b1;
      base   = done_q.size();
      s1     = served_cnt[2];
      stable = 1'b1;
      set_req(2, 16'haaaa, 16'hbbbb, 16'd1472);
      repeat (5) begin
         @(negedge clk);
         if (!(hdr_valid_in && hdr_src_port == 16'haaaa && hdr_dst_port == 16'hbbbb &&
               hdr_udp_length == 16'd1480 && req_ready == '0))
            stable = 1'b0;
      end
      check("stall_stable", 64'(stable), 64'd1);
      check("stall_not_consumed", 64'(served_cnt[2]), 64'(s1));
      stall = 1'b0;
      @(negedge clk);
      check("stall_ready_after_hs", 64'({req_ready, hdr_valid_in}), 64'b0100_0);
      wait_done("stall_done", base + 1);

      // ---- reset while in WAIT_OUT (pointer is 3 here) ----
      out_rdy = 1'b0;
      base    = done_q.size();
      set_req(1, 16'h1111, 16'h2222, 16'd20);
      wait_out_valid("rst_out_valid");
      s0 = served_cnt[0];
      s3 = served_cnt[3];
      set_req(0, 16'h3333, 16'h4444, 16'd30);
      set_req(3, 16'h5555, 16'h6666, 16'd40);
      rstn = 1'b0;
      @(negedge clk);
      check("rst_outputs_zero", all_outputs(), 64'd0);
      rstn    = 1'b1;
      out_rdy = 1'b1;
      wait_done("rst_two_done", base + 2);
      repeat (10) @(negedge clk);
      check("rst_done_total", 64'(done_q.size()), 64'(base + 2));
      check("rst_first_ptr0", 64'(q_at(done_q, base)), 64'd0);
      check("rst_second", 64'(q_at(done_q, base + 1)), 64'd3);
      check("rst_served", 64'({served_cnt[0], served_cnt[3]}), 64'({s0 + 1, s3 + 1}));

      // ---- invariants over the whole run ----
      check("one_hot_req_ready", 64'(multi_rr), 64'd0);
      check("done_err_exclusive", 64'(both_pulse), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_udp_hdr_scheduler

// File: doc/udp_hdr_scheduler.md
Name: udp_hdr_scheduler

Overview:
Round-robin scheduler that shares one UDP header builder among NUM_REQ requesters, such as RDMA queue-pair send engines.
- Selects one pending request, checks its payload length and computes the UDP length as payload + 8.
- Drives the builder's input handshake, then watches the builder's output handshake.
- When that header has been accepted downstream, reports the requester ID.
- Only one header is in flight at a time, which matches the builder's single-entry behaviour.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of the requester index; must equal clog2(NUM_REQ)
MAX_PAYLOAD, 1472, largest legal payload in bytes; anything larger is rejected

Ports:
clk  in  1  clock; all logic on the rising edge
rstn  in  1  reset, synchronous, active-low
req_valid  in  NUM_REQ  per-requester request pending; held, with its fields stable, until req_ready
req_ready  out  NUM_REQ  one-cycle pulse that consumes the request (issued or rejected)
req_src_port  in  NUM_REQ*16  packed source ports; requester i at [16i+15:16i]
req_dst_port  in  NUM_REQ*16  packed destination ports
req_payload_len  in  NUM_REQ*16  packed payload lengths in bytes
hdr_valid_in  out  1  valid to the builder
hdr_ready_in  in  1  ready from the builder
hdr_src_port  out  16  source port to the builder
hdr_dst_port  out  16  destination port to the builder
hdr_udp_length  out  16  UDP length to the builder (payload + 8)
hdr_out_valid  in  1  builder valid_out (monitored only)
hdr_out_ready  in  1  downstream ready_out (monitored only)
done_valid  out  1  one-cycle pulse: the issued header was accepted downstream
done_id  out  ID_W  requester ID for done_valid
err_valid  out  1  one-cycle pulse: a request was rejected as oversize
err_id  out  ID_W  requester ID for err_valid

Behaviour:
- Reset values: every output is 0 (req_ready, hdr_valid_in, hdr_* fields, done_*, err_*); state = IDLE; round-robin pointer rr_ptr = 0.
- State IDLE:
  - If any req_valid is high, grant the first set bit searching upward from rr_ptr and wrapping modulo NUM_REQ.
  - Latch the granted requester's ports and length.
  - If len > MAX_PAYLOAD: next cycle pulse req_ready[g], err_valid, err_id = g; set rr_ptr = g+1 (mod); stay in IDLE. Nothing is sent to the builder.
  - Otherwise: register hdr_udp_length = len + 8 (16-bit); go to ISSUE. hdr_valid_in rises the cycle after the grant.
- State ISSUE:
  - hdr_valid_in = 1 and the hdr_* fields are held stable until hdr_ready_in is high.
  - On the handshake cycle: hdr_valid_in drops next cycle, req_ready[g] pulses next cycle, go to WAIT_OUT.
- State WAIT_OUT:
  - Wait for hdr_out_valid and hdr_out_ready high together.
  - Then: pulse done_valid with done_id = g; set rr_ptr = g+1 (mod); return to IDLE.
  - A new grant may be evaluated in the cycle after done_valid; no earlier.
- Arithmetic: MAX_PAYLOAD ≤ 65527 guarantees len + 8 cannot overflow 16 bits. Lengths 0..MAX_PAYLOAD are legal; a length of 0 gives UDP length 8.
- Throughput: one header per at least 4 cycles (grant, issue, builder output, done).
- req_ready pulses exactly once per consumed request and is never high for two requesters in the same cycle.
- A requester dropping req_valid before req_ready is a protocol violation; behaviour is unspecified, but the grant stays locked until issue completes.
- Simultaneous events:
  - done_valid and err_valid are never high together; err happens only in IDLE.
  - A new req_valid arriving during ISSUE or WAIT_OUT waits; it is not lost.
- Fairness: after requester g is served, g has lowest priority. With all requesters continuously valid, the service order is 0,1,2,3,0,...
- Reset mid-operation: rstn low in any state returns to IDLE with all outputs 0 at the next edge. The in-flight request is not consumed (no req_ready pulse). The builder must be reset by the same rstn.

Decomposition:
- Shared package (udp_pkg): UDP_HDR_BYTES = 8, MAX_UDP_PAYLOAD = 1472, and the state encoding typedef {IDLE, ISSUE, WAIT_OUT}.
- One natural sub-module: rr_arbiter (NUM_REQ-wide request vector plus pointer in, one-hot grant and index out; combinational priority rotate).

Test Plan:
- Single request: req 2 with src 0x1234, dst 0x4791, len 100 → hdr fields 0x1234 / 0x4791 / 108; builder header 0x1234_4791_006C_0000; req_ready[2] pulses once; done_id = 2.
- All four requesters valid continuously for 8 headers → done_id sequence 0,1,2,3,0,1,2,3; each req_ready pulses exactly twice.
- Oversize: req 1 with len 1473 and req 3 with len 1472 → err_valid with err_id = 1 and no hdr_valid_in for it; req 3 is issued with UDP length 1480 and done_id = 3.
- Backpressure: hold hdr_out_ready low for 10 cycles after builder valid_out → no new hdr_valid_in and no done_valid until it rises; done_valid follows one cycle after acceptance.
- Builder stall: hold hdr_ready_in low for 5 cycles → hdr_valid_in and fields stay stable throughout; req_ready pulses only after the handshake.
- Reset in WAIT_OUT: assert rstn low for 1 cycle → all outputs 0; rr_ptr = 0; the pending requester is re-granted after reset and produces exactly one done pulse.
